// File: rtl/resize_pkg.sv
// Shared types and default geometry for the decimator / frame-writer pair.
package resize_pkg;

  localparam int DEF_DATA_W     = 24;
  localparam int DEF_OUT_W      = 320;
  localparam int DEF_OUT_H      = 240;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } state_e;

  // Coordinate-tagged pixel at the default geometry; the writer builds the
  // same field layout at its own parameterised widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0]        data;
    logic [$clog2(DEF_OUT_W)-1:0] x;
    logic [$clog2(DEF_OUT_H)-1:0] y;
    logic                         sof;
    logic                         eol;
    logic                         eof;
  } entry_t;

endpackage

// File: rtl/resize_sync_fifo.sv
// Single-clock FIFO with registered count. Push and pop may coincide at full;
// the caller is responsible for never pushing into a full FIFO without a pop.
module resize_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;

  // Next-state: write at wr pointer, advance pointers, track occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Storage is reset too so the head reads zero straight out of reset.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/resize_frame_writer.sv
// Tags kept pixels from the 2:1 decimator with frame coordinates and queues
// them for the downstream frame-buffer stage; reports done/short/overflow.
module resize_frame_writer
  import resize_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int OUT_H      = DEF_OUT_H,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     iVS,
  input  logic                     iResize_valid,
  input  logic [DATA_W-1:0]        iData,
  output logic [DATA_W-1:0]        oData,
  output logic [$clog2(OUT_W)-1:0] oX,
  output logic [$clog2(OUT_H)-1:0] oY,
  output logic                     oSOF,
  output logic                     oEOL,
  output logic                     oEOF,
  output logic                     oValid,
  input  logic                     iReady,
  output logic                     oFrame_done,
  output logic                     oShort_frame,
  output logic                     oOverflow
);
  localparam int XW = $clog2(OUT_W);
  localparam int YW = $clog2(OUT_H);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              sof;
    logic              eol;
    logic              eof;
  } ent_t;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          done_q, done_d;
  logic          short_q, short_d;
  logic          ovf_q, ovf_d;

  logic acc, push, pop, full, empty;
  logic tag_sof, tag_eol, tag_eof;
  ent_t wr_ent, rd_ent;

  // A pixel counts only in ACTIVE; a coincident iVS takes priority over it.
  assign acc     = (state_q == ACTIVE) && iResize_valid && !iVS;
  assign pop     = !empty && iReady;
  assign push    = acc && (!full || pop);

  assign tag_sof = (x_q == '0) && (y_q == '0);
  assign tag_eol = (x_q == XW'(OUT_W-1));
  assign tag_eof = tag_eol && (y_q == YW'(OUT_H-1));

  assign wr_ent  = '{data: iData, x: x_q, y: y_q,
                     sof: tag_sof, eol: tag_eol, eof: tag_eof};

  // Frame FSM: counters advance on every accepted pixel, pushed or dropped,
  // so geometry survives an overflow.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    short_d = 1'b0;
    ovf_d   = ovf_q;
    if (iVS) begin
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
      short_d = (state_q == ACTIVE);
    end else if (acc) begin
      if (!push) ovf_d = 1'b1;
      if (tag_eol) begin
        x_d = '0;
        y_d = tag_eof ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      if (tag_eof) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
    end
  end

  resize_sync_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iclk   (iclk),
    .irst_n (irst_n),
    .push   (push),
    .wdata  (wr_ent),
    .pop    (pop),
    .rdata  (rd_ent),
    .full   (full),
    .empty  (empty)
  );

  assign oData        = rd_ent.data;
  assign oX           = rd_ent.x;
  assign oY           = rd_ent.y;
  assign oSOF         = rd_ent.sof;
  assign oEOL         = rd_ent.eol;
  assign oEOF         = rd_ent.eof;
  assign oValid       = !empty;
  assign oFrame_done  = done_q;
  assign oShort_frame = short_q;
  assign oOverflow    = ovf_q;

endmodule
